// File: rtl/pulse_sequencer_pkg.sv
// Shared definitions for the pulse sequencer: FSM state encoding and
// the helper macro that slices one channel out of a flattened config bus.
`ifndef PULSE_SEQUENCER_PKG_SV
`define PULSE_SEQUENCER_PKG_SV

// Channel i of a bus packed as consecutive w-bit fields.
`define PS_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package pulse_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`endif

// File: rtl/pulse_sequencer_window.sv
// pulse_window: one channel's registered pulse window.
// Ports: clock/reset, i_count (shared tick), i_delay/i_width (channel
// config), i_run (sequence running), o_window (registered pulse bit).
module pulse_window #(
    parameter int counter_width = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [counter_width:0]   i_count,
    input  logic [counter_width-1:0] i_delay,
    input  logic [counter_width-1:0] i_width,
    input  logic                     i_run,
    output logic                     o_window
);

    logic [counter_width:0] w_begin;
    logic [counter_width:0] w_stop;
    logic                   r_window;

    // One extra bit keeps delay+width from wrapping.
    assign w_begin = {1'b0, i_delay};
    assign w_stop  = w_begin + {1'b0, i_width};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_window <= 1'b0;
        end else begin
            r_window <= i_run
                     && (i_count >= w_begin)
                     && (i_count < w_stop);
        end
    end

    assign o_window = r_window;

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: on start, each channel emits one pulse at its own
// delay/width, timed from one shared tick counter.
// Ports: clock, reset (sync, active-high), start, abort,
// delay_config/width_config (flattened per channel), channel_out,
// busy (RUN or DONE), done (one-cycle completion strobe).
module pulse_sequencer
    import pulse_sequencer_pkg::*;
#(
    parameter int channel_count = 4,
    parameter int counter_width = 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [channel_count*counter_width-1:0] delay_config,
    input  logic [channel_count*counter_width-1:0] width_config,
    output logic [channel_count-1:0]               channel_out,
    output logic                                   busy,
    output logic                                   done
);

    localparam int CW = counter_width + 1;
    localparam int BW = channel_count * counter_width;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   r_end;
    logic [CW-1:0]   w_end_in;
    logic [BW-1:0]   r_dly;
    logic [BW-1:0]   r_wid;
    logic [BW-1:0]   w_dly;
    logic [BW-1:0]   w_wid;
    logic            w_capture;
    logic            w_run_nxt;
    logic            r_busy;
    logic            r_done;

    // Last tick of the run, over enabled channels only.
    always_comb begin : end_calc
        logic [CW-1:0] sum;
        sum      = '0;
        w_end_in = '0;
        for (int i = 0; i < channel_count; i++) begin
            sum = {1'b0, `PS_SLICE(delay_config, i, counter_width)}
                + {1'b0, `PS_SLICE(width_config, i, counter_width)};
            if ((`PS_SLICE(width_config, i, counter_width) != '0)
                && (sum > w_end_in)) begin
                w_end_in = sum;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (w_end_in == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + {{counter_width{1'b0}}, 1'b1};
                    if (w_cnt_nxt == r_end) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_end   <= '0;
            r_dly   <= '0;
            r_wid   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_dly <= delay_config;
                r_wid <= width_config;
                r_end <= w_end_in;
            end
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    // Windows are evaluated on next-cycle values so the registered
    // outputs line up with the state register (tick 0 right after start).
    assign w_dly     = w_capture ? delay_config : r_dly;
    assign w_wid     = w_capture ? width_config : r_wid;
    assign w_run_nxt = (w_state_nxt == ST_RUN);

    for (genvar g = 0; g < channel_count; g++) begin : g_ch
        pulse_window #(
            .counter_width(counter_width)
        ) u_win (
            .clock   (clock),
            .reset   (reset),
            .i_count (w_cnt_nxt),
            .i_delay (`PS_SLICE(w_dly, g, counter_width)),
            .i_width (`PS_SLICE(w_wid, g, counter_width)),
            .i_run   (w_run_nxt),
            .o_window(channel_out[g])
        );
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: directed plus random runs,
// expected waveforms precomputed per run from delay/width rules.
module tb_pulse_sequencer;

    localparam int CH = 4;
    localparam int W  = 8;

    typedef struct packed {
        logic [CH-1:0] ch;
        logic          busy;
        logic          done;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [CH*W-1:0] delay_config = '0;
    logic [CH*W-1:0] width_config = '0;
    logic [CH-1:0]   channel_out;
    logic            busy;
    logic            done;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;
    exp_t plan[$];
    exp_t expq[$];
    exp_t mon_e;
    bit   cur_busy = 0;

    pulse_sequencer #(
        .channel_count(CH),
        .counter_width(W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .delay_config(delay_config),
        .width_config(width_config),
        .channel_out (channel_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Whole-run waveform: one entry per cycle after the start edge.
    function automatic void build_plan();
        int   d[CH];
        int   w[CH];
        int   endv;
        exp_t e;
        endv = 0;
        for (int i = 0; i < CH; i++) begin
            d[i] = int'(delay_config[i*W +: W]);
            w[i] = int'(width_config[i*W +: W]);
            if (w[i] > 0 && d[i] + w[i] > endv) endv = d[i] + w[i];
        end
        for (int k = 0; k < endv; k++) begin
            e = '0;
            e.busy = 1'b1;
            for (int i = 0; i < CH; i++)
                if (w[i] > 0 && k >= d[i] && k < d[i] + w[i]) e.ch[i] = 1'b1;
            plan.push_back(e);
        end
        e = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        plan.push_back(e);
    endfunction

    function automatic void model_edge(bit rs, bit st, bit ab);
        exp_t e;
        e = '0;
        if (rs) begin
            plan.delete();
            cur_busy = 0;
        end else if (!cur_busy) begin
            if (st && !ab) begin
                build_plan();
                e = plan.pop_front();
                cur_busy = 1;
            end
        end else if (ab) begin
            plan.delete();
            cur_busy = 0;
        end else if (plan.size() == 0) begin
            cur_busy = 0;
        end else begin
            e = plan.pop_front();
        end
        expq.push_back(e);
    endfunction

    task automatic step(input bit st, input bit ab, input bit rs);
        start = st;
        abort = ab;
        reset = rs;
        @(posedge clock);
        model_edge(rs, st, ab);
        #1;
    endtask

    always @(negedge clock) begin
        n_cyc++;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            n_tests++;
            if ({channel_out, busy, done} !== mon_e) begin
                n_fail++;
                $display("FAIL cycle%0d: got ch=%b busy=%b done=%b, want ch=%b busy=%b done=%b",
                         n_cyc, channel_out, busy, done,
                         mon_e.ch, mon_e.busy, mon_e.done);
            end
        end
    end

    task automatic do_run(input logic [CH*W-1:0] dc, input logic [CH*W-1:0] wc,
                          input int abort_k, input int reset_k, input bit noise);
        delay_config = dc;
        width_config = wc;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 600 && cur_busy; k++) begin
            if (noise) begin
                delay_config = {$urandom, $urandom};
                width_config = {$urandom, $urandom};
            end
            step(noise && ($urandom_range(0, 2) == 0), k == abort_k, k == reset_k);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_cfg(output logic [CH*W-1:0] dc, output logic [CH*W-1:0] wc,
                            input bit big);
        for (int i = 0; i < CH; i++) begin
            dc[i*W +: W] = big ? W'($urandom) : W'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0)
                wc[i*W +: W] = '0;
            else
                wc[i*W +: W] = big ? W'($urandom_range(1, 255))
                                   : W'($urandom_range(1, 12));
        end
    endtask

    initial begin
        logic [CH*W-1:0] dc;
        logic [CH*W-1:0] wc;
        int ak;
        int rk;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // single channel d=3 w=2
        do_run({8'd0, 8'd0, 8'd0, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd2}, -1, -1, 1'b0);
        // delays {0,2,5,5}, widths {1,3,2,0}
        do_run({8'd5, 8'd5, 8'd2, 8'd0}, {8'd0, 8'd2, 8'd3, 8'd1}, -1, -1, 1'b0);
        // all widths zero
        do_run({8'd1, 8'd2, 8'd3, 8'd4}, '0, -1, -1, 1'b0);
        // abort mid-pulse, then immediate restart
        do_run({24'd0, 8'd10}, {24'd0, 8'd4}, 11, -1, 1'b0);
        do_run({24'd0, 8'd10}, {24'd0, 8'd4}, -1, -1, 1'b0);
        // config churn and ignored starts in RUN and DONE
        do_run({8'd1, 8'd4, 8'd0, 8'd6}, {8'd3, 8'd0, 8'd2, 8'd5}, -1, -1, 1'b1);
        // widest window, no wrap
        do_run({24'd0, 8'd255}, {24'd0, 8'd255}, -1, -1, 1'b0);
        // reset mid-run
        do_run({8'd0, 8'd9, 8'd3, 8'd2}, {8'd7, 8'd4, 8'd6, 8'd5}, -1, 4, 1'b0);
        for (int r = 0; r < 40; r++) begin
            rand_cfg(dc, wc, (r % 8) == 7);
            ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
            rk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 25)) : -1;
            do_run(dc, wc, ak, rk, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
